// File: rtl/wb_slave_mem.sv
// WISHBONE classic-cycle slave: word-addressed register memory with byte-lane
// writes, programmable wait states, ERR on out-of-range and periodic RTY.
module wb_slave_mem #(
  parameter int AW          = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0,
  parameter int RTY_EVERY   = 0
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          CYC_I,
  input  logic          STB_I,
  input  logic          WE_I,
  input  logic [AW-1:0] ADR_I,
  input  logic [3:0]    SEL_I,
  input  logic [31:0]   DAT_I,
  input  logic [3:0]    TAG_I,
  output logic [31:0]   DAT_O,
  output logic          ACK_O,
  output logic          ERR_O,
  output logic          RTY_O,
  output logic [3:0]    TAG_O
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-2:0] DEPTH_W = (AW-1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic [15:0]   rcnt_q, rcnt_d;
  logic          we_q;
  logic [AW-3:0] idx_q;
  logic [3:0]    sel_q, tag_q, tag_o_q;
  logic [31:0]   wdat_q, dat_o_q;
  logic          ack_q, err_q, rty_q;
  logic [31:0]   mem_q [DEPTH];
  logic          req, in_rng, do_ack, do_err, do_rty;

  assign req    = CYC_I & STB_I;
  assign in_rng = ({1'b0, idx_q} < DEPTH_W);

  // Termination is decided at the edge that leaves WAIT with wcnt==0.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    do_ack  = 1'b0;
    do_err  = 1'b0;
    do_rty  = 1'b0;
    case (state_q)
      S_IDLE: if (req) begin
        state_d = S_WAIT;
        wcnt_d  = 4'(WAIT_STATES);
      end
      S_WAIT: begin
        if (!CYC_I) state_d = S_IDLE;
        else if (wcnt_q != 4'd0) wcnt_d = wcnt_q - 4'd1;
        else begin
          state_d = S_RESP;
          if (!in_rng) do_err = 1'b1;
          else if (RTY_EVERY > 0 && rcnt_q == 16'(RTY_EVERY - 1)) begin
            do_rty = 1'b1;
            rcnt_d = '0;
          end else begin
            do_ack = 1'b1;
            if (RTY_EVERY > 0) rcnt_d = rcnt_q + 16'd1;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      sel_q   <= '0;
      tag_q   <= '0;
      wdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
      tag_o_q <= '0;
      dat_o_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      ack_q   <= do_ack;
      err_q   <= do_err;
      rty_q   <= do_rty;
      if (state_q == S_IDLE && req) begin
        we_q   <= WE_I;
        idx_q  <= ADR_I[AW-1:2];
        sel_q  <= SEL_I;
        tag_q  <= TAG_I;
        wdat_q <= DAT_I;
      end
      if (do_ack | do_err | do_rty) tag_o_q <= tag_q;
      if (do_ack && !we_q) dat_o_q <= mem_q[idx_q[IW-1:0]];
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_ack && we_q) begin
      for (int b = 0; b < 4; b++)
        if (sel_q[b]) mem_q[idx_q[IW-1:0]][8*b +: 8] <= wdat_q[8*b +: 8];
    end
  end

  assign DAT_O = dat_o_q;
  assign ACK_O = ack_q;
  assign ERR_O = err_q;
  assign RTY_O = rty_q;
  assign TAG_O = tag_o_q;
endmodule

// File: tb/tb_wb_slave_mem.sv
// Directed bench: four slave instances (WS0, WS3, WS0+RTY3, WS2) on a shared
// bus, each selected by its own CYC line.
module tb_wb_slave_mem;
  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       cyc;
  logic             stb, we;
  logic [7:0]       adr;
  logic [3:0]       sel, tag;
  logic [31:0]      dat;
  logic [3:0][31:0] dat_o;
  logic [3:0]       ack, err, rty;
  logic [3:0][3:0]  tag_o;

  int total = 0;
  int bad   = 0;

  localparam logic [15:0] WSV  = {4'd2, 4'd0, 4'd3, 4'd0};
  localparam logic [15:0] RTYV = {4'd0, 4'd3, 4'd0, 4'd0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    wb_slave_mem #(
      .AW(8), .DEPTH(16),
      .WAIT_STATES(int'(WSV[g*4 +: 4])),
      .RTY_EVERY(int'(RTYV[g*4 +: 4]))
    ) u_dut (
      .CLK_I(clk), .RST_I(rst), .CYC_I(cyc[g]), .STB_I(stb), .WE_I(we),
      .ADR_I(adr), .SEL_I(sel), .DAT_I(dat), .TAG_I(tag),
      .DAT_O(dat_o[g]), .ACK_O(ack[g]), .ERR_O(err[g]), .RTY_O(rty[g]),
      .TAG_O(tag_o[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // k = {rty,err,ack} seen at termination; lat = edges after the request edge
  task automatic xfer(input int d, input logic w, input logic [7:0] a,
                      input logic [3:0] s, input logic [31:0] wd,
                      input logic [3:0] t, output logic [2:0] k, output int lat);
    @(negedge clk);
    cyc = 4'(1 << d); stb = 1'b1; we = w; adr = a; sel = s; dat = wd; tag = t;
    @(posedge clk);
    lat = 0; k = 3'b000;
    while (k == 3'b000 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      k = {rty[d], err[d], ack[d]};
    end
    cyc = '0; stb = 1'b0;
    if (k == 3'b000) chk("timeout", 32'(lat), 32'd0);
    @(posedge clk); #1;
    chk("term_one_cycle", 32'({rty[d], err[d], ack[d]}), 32'd0);
  endtask

  logic [2:0] k;
  int         lat;
  logic [2:0] seen;
  logic [2:0] rexp [6] = '{3'b001, 3'b001, 3'b100, 3'b001, 3'b001, 3'b100};

  initial begin
    rst = 1'b1; cyc = '0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat = '0; tag = '0;
    #12;
    for (int i = 0; i < 4; i++) begin
      chk("rst_term", 32'({rty[i], err[i], ack[i]}), 32'd0);
      chk("rst_dat", dat_o[i], 32'd0);
    end
    @(negedge clk); rst = 1'b0;

    // WS=0: full write then read
    xfer(0, 1'b1, 8'h04, 4'hF, 32'hDEADBEEF, 4'h1, k, lat);
    chk("w0_kind", 32'(k), 32'd1); chk("w0_lat", 32'(lat), 32'd1);
    xfer(0, 1'b0, 8'h04, 4'hF, 32'h0, 4'h2, k, lat);
    chk("r0_kind", 32'(k), 32'd1); chk("r0_lat", 32'(lat), 32'd1);
    chk("r0_dat", dat_o[0], 32'hDEADBEEF); chk("r0_tag", 32'(tag_o[0]), 32'h2);

    // byte lanes
    xfer(0, 1'b1, 8'h08, 4'b0101, 32'h11223344, 4'h3, k, lat);
    xfer(0, 1'b0, 8'h08, 4'hF, 32'h0, 4'h3, k, lat);
    chk("lane_dat", dat_o[0], 32'h00220044);
    xfer(0, 1'b1, 8'h08, 4'b0000, 32'hFFFFFFFF, 4'h3, k, lat);
    chk("sel0_kind", 32'(k), 32'd1);
    xfer(0, 1'b0, 8'h08, 4'hF, 32'h0, 4'h3, k, lat);
    chk("sel0_dat", dat_o[0], 32'h00220044);

    // out of range then last word
    xfer(0, 1'b0, 8'h40, 4'hF, 32'h0, 4'h7, k, lat);
    chk("oor_kind", 32'(k), 32'd2); chk("oor_dat", dat_o[0], 32'h00220044);
    chk("oor_tag", 32'(tag_o[0]), 32'h7);
    xfer(0, 1'b0, 8'h3C, 4'hF, 32'h0, 4'h8, k, lat);
    chk("last_kind", 32'(k), 32'd1); chk("last_dat", dat_o[0], 32'h0);

    // WS=3 latency and tag
    xfer(1, 1'b0, 8'h00, 4'hF, 32'h0, 4'hA, k, lat);
    chk("ws3_kind", 32'(k), 32'd1); chk("ws3_lat", 32'(lat), 32'd4);
    chk("ws3_tag", 32'(tag_o[1]), 32'hA); chk("ws3_dat", dat_o[1], 32'h0);

    // WS=3 abort: CYC dropped in second wait cycle
    @(negedge clk);
    cyc = 4'b0010; stb = 1'b1; we = 1'b1; adr = 8'h00; sel = 4'hF; dat = 32'h55; tag = 4'hB;
    @(posedge clk); @(posedge clk); #1;
    cyc = '0; stb = 1'b0;
    seen = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      seen |= {rty[1], err[1], ack[1]};
    end
    chk("abort_term", 32'(seen), 32'd0);
    xfer(1, 1'b0, 8'h00, 4'hF, 32'h0, 4'hC, k, lat);
    chk("abort_lat", 32'(lat), 32'd4); chk("abort_dat", dat_o[1], 32'h0);

    // RTY every 3rd in-range request
    for (int i = 0; i < 6; i++) begin
      xfer(2, 1'b1, 8'h0C, 4'hF, 32'(i + 1), 4'(i), k, lat);
      chk($sformatf("rty_kind%0d", i), 32'(k), 32'(rexp[i]));
    end
    xfer(2, 1'b0, 8'h0C, 4'hF, 32'h0, 4'hD, k, lat);
    chk("rty_rd_kind", 32'(k), 32'd1); chk("rty_rd_dat", dat_o[2], 32'd5);

    // WS=2: reset in the middle of a write
    xfer(3, 1'b1, 8'h10, 4'hF, 32'h12345678, 4'h5, k, lat);
    chk("ws2_lat", 32'(lat), 32'd3);
    xfer(3, 1'b0, 8'h10, 4'hF, 32'h0, 4'h6, k, lat);
    chk("ws2_dat", dat_o[3], 32'h12345678); chk("ws2_tag", 32'(tag_o[3]), 32'h6);
    @(negedge clk);
    cyc = 4'b1000; stb = 1'b1; we = 1'b1; adr = 8'h10; sel = 4'hF; dat = 32'hCAFEF00D; tag = 4'h9;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("mid_rst_term", 32'({rty[3], err[3], ack[3]}), 32'd0);
    chk("mid_rst_dat", dat_o[3], 32'h0); chk("mid_rst_tag", 32'(tag_o[3]), 32'h0);
    cyc = '0; stb = 1'b0;
    @(negedge clk); rst = 1'b0;
    xfer(3, 1'b0, 8'h10, 4'hF, 32'h0, 4'h1, k, lat);
    chk("post_rst_lat", 32'(lat), 32'd3); chk("post_rst_dat", dat_o[3], 32'h0);
    xfer(0, 1'b0, 8'h04, 4'hF, 32'h0, 4'h1, k, lat);
    chk("post_rst_clr", dat_o[0], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
